// File: rtl/sap3_clk_pkg.sv
//----------------------------------------------------------------------------
// Module   : sap3_clk_pkg
// Brief    : Shared types and defaults for the SAP-3 clock-enable controller
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package sap3_clk_pkg;

  // Controller state, also exported on state_o for debug LEDs.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MANUAL = 2'd1,
    HALTED = 2'd2,
    RESUME = 2'd3
  } clk_state_t;

  localparam int DEFAULT_DIV = 4;
  localparam int CNT_W       = 16;

endpackage

`default_nettype wire

// File: rtl/clk_en_div.sv
//----------------------------------------------------------------------------
// Module   : clk_en_div
// Brief    : Programmable divide ratio register and terminal-count counter
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module clk_en_div #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,    // latch div_in and restart the count
  input  logic [DIV_W-1:0] div_in,
  input  logic             clr,     // restart the count, keep the ratio
  input  logic             run,     // count this cycle
  output logic             tc       // count has reached div_eff-1
);

  logic [DIV_W-1:0] ratio;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] div_eff;

  // Ratios 0 and 1 both mean a pulse on every cycle.
  assign div_eff = (ratio < DIV_W'(2)) ? DIV_W'(1) : ratio;
  assign tc      = (count == (div_eff - DIV_W'(1)));

  // Ratio register and wrapping counter; a load always restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ratio <= DIV_W'(DEFAULT_DIV);
      count <= '0;
    end else begin
      if (load) begin
        ratio <= div_in;
      end
      if (load || clr) begin
        count <= '0;
      end else if (run) begin
        count <= tc ? '0 : count + DIV_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
//----------------------------------------------------------------------------
// Module   : cpu_clk_ctrl
// Brief    : CPU clock-enable sequencer: free-run divide, single step, halt
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module cpu_clk_ctrl
  import sap3_clk_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = sap3_clk_pkg::DEFAULT_DIV,
  parameter int CNT_W       = sap3_clk_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  input  logic             mode_i,
  input  logic             step_i,
  input  logic             hlt_i,
  input  logic             resume_i,
  output logic             clk_en_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  clk_state_t       state;
  clk_state_t       next_state;
  logic             clk_en;
  logic             next_en;
  logic             step_q;
  logic [CNT_W-1:0] cycle_cnt;
  logic             cnt_clr;
  logic             cnt_run;
  logic             tc;

  clk_en_div #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .load   (div_load_i),
    .div_in (div_i),
    .clr    (cnt_clr),
    .run    (cnt_run),
    .tc     (tc)
  );

  // Next-state and pulse decision; a ratio load suppresses the pulse but
  // leaves the state transition intact.
  always_comb begin
    next_state = state;
    next_en    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_run    = 1'b0;
    unique case (state)
      RUN: begin
        if (hlt_i) begin
          next_state = HALTED;
          cnt_clr    = 1'b1;
        end else if (mode_i) begin
          next_state = MANUAL;
          cnt_clr    = 1'b1;
        end else begin
          cnt_run = 1'b1;
          next_en = tc;
        end
      end
      MANUAL: begin
        if (hlt_i) begin
          next_state = HALTED;
          cnt_clr    = 1'b1;
        end else if (!mode_i) begin
          next_state = RUN;
          cnt_clr    = 1'b1;
        end else begin
          next_en = step_i & ~step_q;
        end
      end
      HALTED: begin
        if (resume_i) begin
          next_state = RESUME;
          next_en    = 1'b1;  // one pulse lets the CPU step past HLT
        end
      end
      RESUME: begin
        next_state = mode_i ? MANUAL : RUN;
        cnt_clr    = 1'b1;
      end
      default: begin
        next_state = RUN;
        cnt_clr    = 1'b1;
      end
    endcase
    if (div_load_i) begin
      next_en = 1'b0;
    end
  end

  // State, registered enable, step history and pulse counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      clk_en    <= 1'b0;
      step_q    <= 1'b1;  // a step held across reset must not look like an edge
      cycle_cnt <= '0;
    end else begin
      state  <= next_state;
      clk_en <= next_en;
      step_q <= step_i;
      if (clk_en) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

  assign clk_en_o    = clk_en;
  assign state_o     = state;
  assign cycle_cnt_o = cycle_cnt;

endmodule

`default_nettype wire
